sramlike_axi_bridge_mp: RTL and testbench
=========================================

// Module: sramlike_axi_bridge_mp
// PURPOSE
//  Multi-port SRAM-like to AXI3 bridge; next-generation CPU memory adapter.
//  NPORT SRAM-like masters (port 0 = inst, port 1 = data, more for DMA/debug) share one single-beat AXI master.
//  Supports MAX_RD outstanding reads per port; the AXI ID is the port index.
//  Applies the physical address mask internally. Sits between mycpu and the SoC crossbar.
// PARAMETERS
//  NPORT      2    number of SRAM-like ports (1..16; AXI ID is 4 bits)
//  ADDR_KEEP  29   low address bits kept; araddr/awaddr[31:ADDR_KEEP] forced to 0
//  MAX_RD     2    outstanding reads per port (1..15)
// PORTS
//  clk        in   1          clock
//  resetn     in   1          synchronous reset, active low
//  s_req      in   NPORT      per-port request
//  s_wr       in   NPORT      per-port 1 = write
//  s_size     in   2*NPORT    per-port size: 0 byte, 1 half, 2 word
//  s_addr     in   32*NPORT   per-port byte address
//  s_wdata    in   32*NPORT   per-port write data, lane-aligned
//  s_rdata    out  32*NPORT   per-port read data, valid with s_data_ok
//  s_addr_ok  out  NPORT      request accepted this cycle
//  s_data_ok  out  NPORT      response this cycle
//  arid       out  4          read ID = port index
//  araddr     out  32         masked read address
//  arsize     out  3          {1'b0, size}
//  arvalid    out  1          read address valid
//  arready    in   1          read address ready
//  rid        in   4          read response ID
//  rdata      in   32         read data
//  rvalid     in   1          read data valid
//  rready     out  1          read data ready
//  awaddr     out  32         masked write address
//  awsize     out  3          {1'b0, size}
//  awvalid    out  1          write address valid
//  awready    in   1          write address ready
//  wdata      out  32         write data
//  wstrb      out  4          byte strobes
//  wvalid     out  1          write data valid
//  wready     in   1          write data ready
//  bvalid     in   1          write response valid
//  bready     out  1          write response ready
// BEHAVIOUR
//  Reset: all valid/ready/ok outputs 0; rd counters 0; AR slot empty; write FSM IDLE.
//    Reset mid-transaction aborts all state at that edge.
//  Arbitration:
//    - At most one request accepted per cycle; fixed priority, highest port index first.
//    - s_addr_ok[i] is combinational, same cycle as grant.
//  Read grant: AR slot empty, rdcnt[i] < MAX_RD, port i has no pending write,
//    and addr[ADDR_KEEP-1:2] differs from any pending write address (cross-port RAW hold).
//  AR path:
//    - Registered; arvalid = 1 from the cycle after grant, held with stable fields until arready.
//    - Slot refills the cycle after it frees.
//    - rdcnt[i]++ at grant; rdcnt[i]-- on rvalid with rid = i.
//    - rdcnt[i]++ and rdcnt[i]-- in the same cycle leave rdcnt[i] unchanged.
//  R path: rready = 1 whenever out of reset.
//    - On rvalid with rid = i < NPORT: s_data_ok[i] = 1, s_rdata[i] = rdata, same cycle (0 latency).
//    - rid >= NPORT is consumed and dropped.
//    - The slave returns same-ID reads in order, so per-port response order equals issue order.
//  Write FSM: IDLE -> AW_W -> RESP -> IDLE; one write in flight, all ports.
//    - Grant in IDLE only, and only if rdcnt[i] == 0.
//    - AW_W: awvalid and wvalid rise together; each drops on its own handshake.
//      Go to RESP when both have completed, in either order.
//    - RESP: bready = 1. On bvalid, s_data_ok[owner] = 1 and return to IDLE.
//  wstrb (a = addr[1:0]): size 0 -> 4'b0001<<a; size 1 -> 4'b0011<<a; size 2 -> 4'b1111.
//    wdata is passed unmodified.
//  Read s_data_ok on port j and write s_data_ok on port k in the same cycle: both asserted; j != k by construction.
// TESTING
//  1. Reset, then port0 read 0xBFC00000 with arready = 1 -> araddr 0x1FC00000, arid 0; data_ok[0] in the same cycle as rvalid.
//  2. Port0 issues 3 reads, R stalled -> 2 addr_ok, third held until the first rvalid (rid 0); rdata returned in order.
//  3. Port1 and port0 request in the same cycle -> port1 granted first, port0 granted the next free cycle.
//  4. Port1 store byte to 0x80000003 -> awaddr 0x00000003, wstrb 4'b1000; awready 2 cycles after wready -> data_ok[1] on bvalid.
//  5. Write to 0x100 pending, port0 reads 0x100 -> addr_ok[0] = 0 until bvalid, then granted.
//  6. Reset asserted with arvalid = 1 and write in RESP -> all outputs 0 and counters cleared next edge; new read proceeds normally.

Source files
------------

// File: rtl/sramlike_axi_bridge_mp.sv
// Multi-port SRAM-like to single-beat AXI3 bridge: fixed-priority arbitration, one AR slot,
// per-port outstanding-read counters and a single in-flight write with cross-port RAW hold.
module sramlike_axi_bridge_mp #(
    parameter int unsigned NPORT     = 2,
    parameter int unsigned ADDR_KEEP = 29,
    parameter int unsigned MAX_RD    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NPORT-1:0]     s_req,
    input  logic [NPORT-1:0]     s_wr,
    input  logic [2*NPORT-1:0]   s_size,
    input  logic [32*NPORT-1:0]  s_addr,
    input  logic [32*NPORT-1:0]  s_wdata,
    output logic [32*NPORT-1:0]  s_rdata,
    output logic [NPORT-1:0]     s_addr_ok,
    output logic [NPORT-1:0]     s_data_ok,
    output logic [3:0]           arid,
    output logic [31:0]          araddr,
    output logic [2:0]           arsize,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [3:0]           rid,
    input  logic [31:0]          rdata,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [31:0]          awaddr,
    output logic [2:0]           awsize,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic                 bvalid,
    output logic                 bready
);

    localparam logic [31:0] AddrMask = 32'((64'd1 << ADDR_KEEP) - 64'd1);

    typedef enum logic [1:0] {StIdle, StAwW, StResp} wr_state_e;

    wr_state_e   wr_state_q, wr_state_d;
    logic        aw_pend_q, w_pend_q;
    logic [3:0]  wr_owner_q;
    logic [31:0] wr_addr_q, wr_data_q;
    logic [1:0]  wr_size_q;
    logic        wr_resp_ok;

    logic        ar_valid_q;
    logic [3:0]  ar_id_q;
    logic [31:0] ar_addr_q;
    logic [1:0]  ar_size_q;

    logic [3:0]  rdcnt_q [NPORT];

    logic [NPORT-1:0] rd_elig, wr_elig, raw_hit, own_wr, rd_inc, rd_dec;
    logic             gnt_any, gnt_wr;
    logic [3:0]       gnt_idx;
    logic [31:0]      sel_addr, sel_wdata;
    logic [1:0]       sel_size;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            raw_hit[i] = (wr_state_q != StIdle) &&
                         (s_addr[32*i+2 +: ADDR_KEEP-2] == wr_addr_q[ADDR_KEEP-1:2]);
            own_wr[i]  = (wr_state_q != StIdle) && (wr_owner_q == 4'(i));
            rd_elig[i] = resetn && s_req[i] && !s_wr[i] && !ar_valid_q &&
                         (rdcnt_q[i] < 4'(MAX_RD)) && !own_wr[i] && !raw_hit[i];
            wr_elig[i] = resetn && s_req[i] && s_wr[i] && (wr_state_q == StIdle) &&
                         (rdcnt_q[i] == 4'd0);
        end
    end

    // Later iterations overwrite earlier ones, so the highest eligible index wins.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_wr    = 1'b0;
        gnt_idx   = 4'd0;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        sel_size  = 2'd0;
        for (int i = 0; i < NPORT; i++) begin
            if (rd_elig[i] || wr_elig[i]) begin
                gnt_any   = 1'b1;
                gnt_wr    = s_wr[i];
                gnt_idx   = 4'(i);
                sel_addr  = s_addr[32*i +: 32];
                sel_wdata = s_wdata[32*i +: 32];
                sel_size  = s_size[2*i +: 2];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            s_addr_ok[i] = gnt_any && (gnt_idx == 4'(i));
            rd_inc[i]    = s_addr_ok[i] && !gnt_wr;
            rd_dec[i]    = resetn && rvalid && (rid == 4'(i));
            s_data_ok[i] = rd_dec[i] || (wr_resp_ok && (wr_owner_q == 4'(i)));
            s_rdata[32*i +: 32] = rdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (!resetn) begin
                rdcnt_q[i] <= 4'd0;
            end else if (rd_inc[i] && !rd_dec[i]) begin
                rdcnt_q[i] <= rdcnt_q[i] + 4'd1;
            end else if (rd_dec[i] && !rd_inc[i] && (rdcnt_q[i] != 4'd0)) begin
                rdcnt_q[i] <= rdcnt_q[i] - 4'd1;
            end
        end
    end

    // Grant requires an empty slot, so load and handshake never collide.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_valid_q <= 1'b0;
            ar_id_q    <= 4'd0;
            ar_addr_q  <= 32'd0;
            ar_size_q  <= 2'd0;
        end else begin
            if (ar_valid_q && arready) ar_valid_q <= 1'b0;
            if (gnt_any && !gnt_wr) begin
                ar_valid_q <= 1'b1;
                ar_id_q    <= gnt_idx;
                ar_addr_q  <= sel_addr & AddrMask;
                ar_size_q  <= sel_size;
            end
        end
    end

    assign arvalid = ar_valid_q;
    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = {1'b0, ar_size_q};
    assign rready  = resetn;

    always_ff @(posedge clk) begin
        if (!resetn) wr_state_q <= StIdle;
        else         wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            StIdle:  if (gnt_any && gnt_wr) wr_state_d = StAwW;
            StAwW:   if ((!aw_pend_q || awready) && (!w_pend_q || wready)) wr_state_d = StResp;
            StResp:  if (bvalid) wr_state_d = StIdle;
            default: wr_state_d = StIdle;
        endcase
    end

    always_comb begin
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        wr_resp_ok = 1'b0;
        case (wr_state_q)
            StAwW: begin
                awvalid = aw_pend_q;
                wvalid  = w_pend_q;
            end
            StResp: begin
                bready     = 1'b1;
                wr_resp_ok = bvalid;
            end
            default: ;
        endcase
        case (wr_size_q)
            2'd0:    wstrb = 4'b0001 << wr_addr_q[1:0];
            2'd1:    wstrb = 4'b0011 << wr_addr_q[1:0];
            default: wstrb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_pend_q  <= 1'b0;
            w_pend_q   <= 1'b0;
            wr_owner_q <= 4'd0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            wr_size_q  <= 2'd0;
        end else if (wr_state_q == StIdle && gnt_any && gnt_wr) begin
            aw_pend_q  <= 1'b1;
            w_pend_q   <= 1'b1;
            wr_owner_q <= gnt_idx;
            wr_addr_q  <= sel_addr & AddrMask;
            wr_data_q  <= sel_wdata;
            wr_size_q  <= sel_size;
        end else begin
            if (awvalid && awready) aw_pend_q <= 1'b0;
            if (wvalid && wready)   w_pend_q  <= 1'b0;
        end
    end

    assign awaddr = wr_addr_q;
    assign awsize = {1'b0, wr_size_q};
    assign wdata  = wr_data_q;

endmodule

// File: tb/tb_sramlike_axi_bridge_mp.sv
// Directed bench for sramlike_axi_bridge_mp (NPORT=2): reads, outstanding limit, priority,
// byte/half/word writes, RAW hold and mid-transaction reset.
module tb_sramlike_axi_bridge_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  s_req, s_wr, s_addr_ok, s_data_ok;
    logic [3:0]  s_size;
    logic [63:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  arid, rid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
    logic        bvalid, bready;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sramlike_axi_bridge_mp #(.NPORT(2), .ADDR_KEEP(29), .MAX_RD(2)) dut (
        .clk(clk), .resetn(resetn),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
        s_req[p]            = req;
        s_wr[p]             = wr;
        s_size[2*p +: 2]    = size;
        s_addr[32*p +: 32]  = addr;
        s_wdata[32*p +: 32] = wd;
    endtask

    initial begin
        resetn = 1'b0; s_req = '0; s_wr = '0; s_size = '0; s_addr = '0; s_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        step(); step();
        #1;
        chk("rst arvalid", 64'(arvalid), 64'd0);
        chk("rst awvalid", 64'(awvalid), 64'd0);
        chk("rst wvalid", 64'(wvalid), 64'd0);
        chk("rst bready", 64'(bready), 64'd0);
        chk("rst rready", 64'(rready), 64'd0);
        chk("rst data_ok", 64'(s_data_ok), 64'd0);
        resetn = 1'b1;
        #1 chk("run rready", 64'(rready), 64'd1);

        // 1: single read, address masking, zero-latency response
        step();
        arready = 1'b1;
        drv(0, 1, 0, 2'd2, 32'hBFC0_0000, 32'h0);
        #1 chk("t1 addr_ok", 64'(s_addr_ok), 64'b01);
        step();
        drv(0, 0, 0, 2'd2, 32'h0, 32'h0);
        #1 chk("t1 arvalid", 64'(arvalid), 64'd1);
        chk("t1 araddr", 64'(araddr), 64'h1FC0_0000);
        chk("t1 arid", 64'(arid), 64'd0);
        chk("t1 arsize", 64'(arsize), 64'b010);
        step();
        #1 chk("t1 ar done", 64'(arvalid), 64'd0);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
        #1 chk("t1 data_ok", 64'(s_data_ok), 64'b01);
        chk("t1 rdata", 64'(s_rdata[31:0]), 64'hDEAD_BEEF);
        step();
        rvalid = 1'b0;

        // 2: outstanding-read limit of two
        drv(0, 1, 0, 2'd2, 32'h0000_1000, 32'h0);
        #1 chk("t2 ok a", 64'(s_addr_ok), 64'b01);
        step();
        drv(0, 1, 0, 2'd2, 32'h0000_1004, 32'h0);
        #1 chk("t2 araddr a", 64'(araddr), 64'h1000);
        chk("t2 slot busy", 64'(s_addr_ok), 64'b00);
        step();
        #1 chk("t2 ok b", 64'(s_addr_ok), 64'b01);
        step();
        drv(0, 1, 0, 2'd2, 32'h0000_1008, 32'h0);
        #1 chk("t2 araddr b", 64'(araddr), 64'h1004);
        step();
        #1 chk("t2 limit", 64'(s_addr_ok), 64'b00);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hA1;
        #1 chk("t2 r1 ok", 64'(s_data_ok), 64'b01);
        chk("t2 r1 data", 64'(s_rdata[31:0]), 64'hA1);
        chk("t2 limit r", 64'(s_addr_ok), 64'b00);
        step();
        rvalid = 1'b0;
        #1 chk("t2 ok c", 64'(s_addr_ok), 64'b01);
        step();
        drv(0, 0, 0, 2'd2, 32'h0, 32'h0);
        #1 chk("t2 araddr c", 64'(araddr), 64'h1008);
        rvalid = 1'b1; rdata = 32'hA2;
        #1 chk("t2 r2 data", 64'(s_rdata[31:0]), 64'hA2);
        step();
        rdata = 32'hA3;
        #1 chk("t2 r3 ok", 64'(s_data_ok), 64'b01);
        chk("t2 r3 data", 64'(s_rdata[31:0]), 64'hA3);
        step();
        rvalid = 1'b0;

        // 3: priority, highest port first; out-of-range rid dropped
        drv(0, 1, 0, 2'd2, 32'h0000_2000, 32'h0);
        drv(1, 1, 0, 2'd2, 32'h0000_3000, 32'h0);
        #1 chk("t3 prio", 64'(s_addr_ok), 64'b10);
        step();
        drv(1, 0, 0, 2'd2, 32'h0, 32'h0);
        #1 chk("t3 arid1", 64'(arid), 64'd1);
        chk("t3 araddr1", 64'(araddr), 64'h3000);
        chk("t3 wait", 64'(s_addr_ok), 64'b00);
        step();
        #1 chk("t3 p0 ok", 64'(s_addr_ok), 64'b01);
        step();
        drv(0, 0, 0, 2'd2, 32'h0, 32'h0);
        #1 chk("t3 arid0", 64'(arid), 64'd0);
        chk("t3 araddr0", 64'(araddr), 64'h2000);
        step();
        rvalid = 1'b1; rid = 4'd1; rdata = 32'hB1;
        #1 chk("t3 r p1", 64'(s_data_ok), 64'b10);
        chk("t3 rdata1", 64'(s_rdata[63:32]), 64'hB1);
        step();
        rid = 4'd0; rdata = 32'hB0;
        #1 chk("t3 r p0", 64'(s_data_ok), 64'b01);
        step();
        rid = 4'd5;
        #1 chk("t3 bad rid", 64'(s_data_ok), 64'b00);
        step();
        rvalid = 1'b0; arready = 1'b0;

        // 4: byte store, W before AW
        drv(1, 1, 1, 2'd0, 32'h8000_0003, 32'hAB00_0000);
        #1 chk("t4 addr_ok", 64'(s_addr_ok), 64'b10);
        step();
        drv(1, 0, 0, 2'd0, 32'h0, 32'h0);
        #1 chk("t4 awvalid", 64'(awvalid), 64'd1);
        chk("t4 wvalid", 64'(wvalid), 64'd1);
        chk("t4 awaddr", 64'(awaddr), 64'h3);
        chk("t4 wstrb", 64'(wstrb), 64'b1000);
        chk("t4 wdata", 64'(wdata), 64'hAB00_0000);
        chk("t4 awsize", 64'(awsize), 64'd0);
        wready = 1'b1;
        step();
        wready = 1'b0;
        #1 chk("t4 w drop", 64'(wvalid), 64'd0);
        chk("t4 aw hold", 64'(awvalid), 64'd1);
        step();
        awready = 1'b1;
        #1 chk("t4 aw hold2", 64'(awvalid), 64'd1);
        step();
        awready = 1'b0;
        #1 chk("t4 aw drop", 64'(awvalid), 64'd0);
        chk("t4 bready", 64'(bready), 64'd1);
        chk("t4 no ok", 64'(s_data_ok), 64'b00);
        bvalid = 1'b1;
        #1 chk("t4 data_ok", 64'(s_data_ok), 64'b10);
        step();
        bvalid = 1'b0;
        #1 chk("t4 idle", 64'(bready), 64'd0);

        // 5: RAW hold across ports
        drv(1, 1, 1, 2'd2, 32'h0000_0100, 32'h1122_3344);
        #1 chk("t5 wr ok", 64'(s_addr_ok), 64'b10);
        step();
        drv(1, 0, 0, 2'd2, 32'h0, 32'h0);
        drv(0, 1, 0, 2'd2, 32'h0000_0100, 32'h0);
        #1 chk("t5 hold a", 64'(s_addr_ok), 64'b00);
        chk("t5 wstrb", 64'(wstrb), 64'b1111);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        #1 chk("t5 hold b", 64'(s_addr_ok), 64'b00);
        chk("t5 bready", 64'(bready), 64'd1);
        bvalid = 1'b1;
        #1 chk("t5 wr done", 64'(s_data_ok), 64'b10);
        chk("t5 hold c", 64'(s_addr_ok), 64'b00);
        step();
        bvalid = 1'b0; arready = 1'b1;
        #1 chk("t5 granted", 64'(s_addr_ok), 64'b01);
        step();
        drv(0, 0, 0, 2'd2, 32'h0, 32'h0);
        #1 chk("t5 araddr", 64'(araddr), 64'h100);
        step();
        arready = 1'b0;

        // 6: reset with AR slot full and write in RESP
        drv(1, 1, 1, 2'd1, 32'h0000_0202, 32'hBEEF_0000);
        #1 chk("t6 wr ok", 64'(s_addr_ok), 64'b10);
        step();
        drv(1, 0, 0, 2'd1, 32'h0, 32'h0);
        drv(0, 1, 0, 2'd2, 32'h0000_0400, 32'h0);
        awready = 1'b1; wready = 1'b1;
        #1 chk("t6 rd ok", 64'(s_addr_ok), 64'b01);
        chk("t6 wstrb", 64'(wstrb), 64'b1100);
        step();
        drv(0, 0, 0, 2'd2, 32'h0, 32'h0);
        awready = 1'b0; wready = 1'b0;
        #1 chk("t6 arvalid", 64'(arvalid), 64'd1);
        chk("t6 resp", 64'(bready), 64'd1);
        resetn = 1'b0;
        step();
        chk("t6 rst arvalid", 64'(arvalid), 64'd0);
        chk("t6 rst bready", 64'(bready), 64'd0);
        chk("t6 rst awvalid", 64'(awvalid), 64'd0);
        chk("t6 rst wvalid", 64'(wvalid), 64'd0);
        chk("t6 rst rready", 64'(rready), 64'd0);
        resetn = 1'b1; arready = 1'b1;
        drv(0, 1, 0, 2'd2, 32'hBFC0_0100, 32'h0);
        #1 chk("t6 new rd", 64'(s_addr_ok), 64'b01);
        step();
        drv(0, 0, 0, 2'd2, 32'h0, 32'h0);
        #1 chk("t6 new arvalid", 64'(arvalid), 64'd1);
        chk("t6 new araddr", 64'(araddr), 64'h1FC0_0100);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
